lfsr_range_sampler: RTL and testbench
=====================================

LFSR_RANGE_SAMPLER -- requirements
Module: lfsr_range_sampler

Interface
REQ-001 Parameter WIDTH, default 8: width of the LFSR value, limit and output sample.
REQ-002 Parameter DEPTH, default 4: output FIFO depth, a power of two.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port lfsr_value, input, WIDTH: current LFSR output from the upstream generator.
REQ-006 Port lfsr_enable, output, 1: enable to the upstream LFSR; a high level at an edge means the value is consumed and the LFSR advances.
REQ-007 Port start, input, 1: single-cycle pulse that latches limit and num_samples and begins a run.
REQ-008 Port limit, input, WIDTH: exclusive upper bound; samples lie in [0, limit-1].
REQ-009 Port num_samples, input, 8: accepted samples per run; 0 means continuous.
REQ-010 Port out_data, output, WIDTH: head of the FIFO.
REQ-011 Port out_valid, output, 1: the FIFO is non-empty.
REQ-012 Port out_ready, input, 1: consumer accepts out_data when out_valid and out_ready are both high at an edge.
REQ-013 Port busy, output, 1: the FSM is in RUN.
REQ-014 Port stuck, output, 1: sticky flag for an LFSR lockup.
REQ-015 Port err, output, 1: sticky flag for start with limit equal to 0.
REQ-016 Port reject_cnt, output, 16: rejected candidates since the last start; saturates at 0xFFFF.

Function
REQ-017 The FSM has two states, IDLE and RUN.
REQ-018 In IDLE, start with limit != 0 shall flush the FIFO, clear stuck, err and reject_cnt, latch limit and num_samples, and enter RUN.
REQ-019 In IDLE, start with limit == 0 shall set err, flush nothing, and remain in IDLE.
REQ-020 In RUN, start shall restart the run with the same effects as REQ-018; with limit == 0 it follows REQ-019 and enters IDLE.
REQ-021 lfsr_enable shall equal (state==RUN && fifo_count<DEPTH); it is derived only from registered state.
REQ-022 mask shall be all ones from bit 0 up to the MSB of (limit-1); for limit==1, mask = 0.
REQ-023 At each edge with lfsr_enable high, cand = lfsr_value & mask.
REQ-024 If cand < limit, cand is pushed to the FIFO.
REQ-025 If cand >= limit, cand is discarded and reject_cnt is incremented, saturating.
REQ-026 A pushed sample shall appear on out_data/out_valid the cycle after the consuming edge (first-word fall-through).
REQ-027 A push and a pop at the same edge shall leave fifo_count unchanged.
REQ-028 A pop with the FIFO empty shall be ignored.
REQ-029 The FIFO shall never be pushed when full, because lfsr_enable is low.
REQ-030 When the accepted count reaches a non-zero num_samples, the FSM enters IDLE at the same edge. The FIFO contents remain readable.
REQ-031 Lockup: if two consecutive consumed values are equal, set stuck and enter IDLE at that edge. The second value is not pushed.
REQ-032 All-zero lockup is covered by REQ-031.
REQ-033 The start pulse takes priority over a sample consumed at the same edge; that sample is discarded.

Reset
REQ-034 On reset low, the FSM enters IDLE asynchronously.
REQ-035 On reset low, the FIFO empties, out_valid = 0, out_data = 0, and lfsr_enable = 0.
REQ-036 On reset low, busy = 0, stuck = 0, err = 0, reject_cnt = 0, and the latched limit, num_samples and previous value = 0.
REQ-037 Reset asserted mid-run shall abandon the run; no partial push survives.

Structure
REQ-038 Package lfsr_pkg holds the state enum, the WIDTH default and the mask-from-limit function.
REQ-039 One sub-module, rng_fifo: a parameterised synchronous FIFO with push/pop/count and FWFT output.

Verification
REQ-040 Reset, then drive limit=5, num_samples=2, start. Drive lfsr_value 0x0D then 0x0B then 0x02 with out_ready=1. Required: the first value is rejected (reject_cnt=1); 3 and then 2 are output; busy falls after the second accept.
REQ-041 limit=1, continuous, out_ready=0, lfsr_value stepping 0x11, 0x22, 0x33, 0x44, 0x55. Required: 4 zeros are buffered, lfsr_enable drops to 0 with the FIFO full, and value 0x55 is not consumed.
REQ-042 limit=0, start. Required: err=1, busy=0, lfsr_enable=0 throughout.
REQ-043 limit=200 running; lfsr_value held at 0x37 for two enabled edges. Required: stuck=1, busy=0, exactly one 0x37 in the FIFO.
REQ-044 Full FIFO with out_ready=1 and a new accept. Required: a simultaneous pop and push, count stays at DEPTH-1 or less, data order is preserved.
REQ-045 reset pulsed low mid-run with 3 entries buffered. Required: out_valid=0 and all outputs at their reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR range sampler.
// Holds the FSM encoding, the default sample width and the rejection-mask helper.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Smallest all-ones mask covering limit-1, so a masked candidate is below 2*limit.
  function automatic logic [31:0] mask_from_limit(input logic [31:0] lim);
    logic [31:0] m;
    m = lim - 32'd1;
    for (int i = 0; i < 5; i++) begin
      m = m | (m >> (1 << i));
    end
    return (lim == 32'd0) ? 32'd0 : m;
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// Synchronous FIFO with first-word fall-through output and a synchronous flush.
// Zero-latency head visibility; pushes when full and pops when empty are ignored.
module rng_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem[wr_q] <= data_i;
  end

  // Gate the head so an empty FIFO (including right after reset) shows zero.
  assign data_o  = (cnt_q != '0) ? mem[rd_q] : '0;
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/lfsr_range_sampler.sv
// Rejection sampler turning raw LFSR words into uniform samples in [0, limit-1].
// Samples appear one cycle after consumption; the LFSR is stalled while the FIFO is full.
module lfsr_range_sampler
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lfsr_value,
  output logic             lfsr_enable,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic [7:0]       num_samples,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             stuck,
  output logic             err,
  output logic [15:0]      reject_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [7:0]       nsamp_q, nsamp_d;
  logic [7:0]       acc_q, acc_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic             stuck_q, stuck_d;
  logic             err_q, err_d;
  logic [15:0]      rej_q, rej_d;

  logic [CW-1:0]    fifo_count;
  logic             fifo_flush, fifo_push;
  logic [WIDTH-1:0] mask, cand;

  assign lfsr_enable = (state_q == ST_RUN) && (fifo_count < CW'(DEPTH));
  assign mask        = WIDTH'(mask_from_limit(32'(limit_q)));
  assign cand        = lfsr_value & mask;

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    nsamp_d    = nsamp_q;
    acc_d      = acc_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    stuck_d    = stuck_q;
    err_d      = err_q;
    rej_d      = rej_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;

    // A start pulse wins over any word consumed at the same edge.
    if (start) begin
      if (limit != '0) begin
        fifo_flush = 1'b1;
        stuck_d    = 1'b0;
        err_d      = 1'b0;
        rej_d      = '0;
        limit_d    = limit;
        nsamp_d    = num_samples;
        acc_d      = '0;
        prev_vld_d = 1'b0;
        state_d    = ST_RUN;
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (lfsr_enable) begin
      prev_d     = lfsr_value;
      prev_vld_d = 1'b1;
      if (prev_vld_q && (lfsr_value == prev_q)) begin
        stuck_d = 1'b1;
        state_d = ST_IDLE;
      end else if (cand < limit_q) begin
        fifo_push = 1'b1;
        acc_d     = acc_q + 8'd1;
        if ((nsamp_q != 8'd0) && (acc_d == nsamp_q)) state_d = ST_IDLE;
      end else if (rej_q != 16'hFFFF) begin
        rej_d = rej_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      limit_q    <= '0;
      nsamp_q    <= '0;
      acc_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      stuck_q    <= 1'b0;
      err_q      <= 1'b0;
      rej_q      <= '0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      nsamp_q    <= nsamp_d;
      acc_q      <= acc_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      stuck_q    <= stuck_d;
      err_q      <= err_d;
      rej_q      <= rej_d;
    end
  end

  rng_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (cand),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign busy       = (state_q == ST_RUN);
  assign stuck      = stuck_q;
  assign err        = err_q;
  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// Scoreboard bench for lfsr_range_sampler: a behavioural model predicts samples and flags,
// a negedge monitor compares every visible output and pops expected samples on handshakes.
module tb_lfsr_range_sampler;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] lfsr_value = '0;
  logic         lfsr_enable;
  logic         start = 1'b0;
  logic [W-1:0] limit = '0;
  logic [7:0]   num_samples = '0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy, stuck, err;
  logic [15:0]  reject_cnt;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  always #5 clk = ~clk;

  lfsr_range_sampler #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .lfsr_value  (lfsr_value),
    .lfsr_enable (lfsr_enable),
    .start       (start),
    .limit       (limit),
    .num_samples (num_samples),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .stuck       (stuck),
    .err         (err),
    .reject_cnt  (reject_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Upstream generator: head of a directed list, else random words when enabled.
  logic [W-1:0] vals[$];
  bit           rnd = 1'b0;
  logic         en_s = 1'b0;
  logic [W-1:0] cur = '0;

  always @(negedge clk) en_s = lfsr_enable;

  always @(posedge clk) begin
    #1;
    if (en_s) begin
      if (vals.size() > 0) void'(vals.pop_front());
      else if (rnd) cur = W'($urandom);
    end
    lfsr_value = (vals.size() > 0) ? vals[0] : cur;
  end

  // Reference model.
  bit           m_run = 0, m_stuck = 0, m_err = 0, m_hp = 0;
  int           m_lim = 0, m_n = 0, m_acc = 0, m_rej = 0, m_cnt = 0;
  logic [W-1:0] m_prev = '0;
  logic [W-1:0] exp_q[$];

  function automatic int mask_of(input int l);
    int m = 0;
    while (m < l - 1) m = m * 2 + 1;
    return m;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_stuck = 0; m_err = 0; m_hp = 0;
      m_lim = 0; m_n = 0; m_acc = 0; m_rej = 0; m_cnt = 0; m_prev = '0;
      exp_q.delete();
    end else begin
      bit en, pop;
      int c;
      en  = m_run && (m_cnt < D);
      pop = (m_cnt > 0) && out_ready;
      if (start) begin
        if (limit != 0) begin
          exp_q.delete(); m_cnt = 0;
          m_stuck = 0; m_err = 0; m_rej = 0;
          m_lim = int'(limit); m_n = int'(num_samples); m_acc = 0; m_hp = 0; m_run = 1;
        end else begin
          m_err = 1; m_run = 0;
          if (pop) m_cnt--;
        end
      end else begin
        if (pop) m_cnt--;
        if (en) begin
          c = int'(lfsr_value) & mask_of(m_lim);
          if (m_hp && lfsr_value == m_prev) begin
            m_stuck = 1; m_run = 0;
          end else if (c < m_lim) begin
            exp_q.push_back(W'(c)); m_cnt++; m_acc++;
            if (m_n != 0 && m_acc == m_n) m_run = 0;
          end else if (m_rej < 65535) begin
            m_rej++;
          end
          m_prev = lfsr_value; m_hp = 1;
        end
      end
    end
  end

  // Monitor.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_run));
    chk("lfsr_enable", 32'(lfsr_enable), 32'(m_run && (m_cnt < D)));
    chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
    chk("stuck", 32'(stuck), 32'(m_stuck));
    chk("err", 32'(err), 32'(m_err));
    chk("reject_cnt", 32'(reject_cnt), 32'(m_rej));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_data unexpected sample actual=%0h required=none t=%0t", out_data, $time);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      n_out++;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic go(input int l, input int n);
    limit = W'(l); num_samples = 8'(n); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      tick(1);
      i++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    tick(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_lfsr_enable", 32'(lfsr_enable), 32'd0);
    reset = 1'b1;
    tick(2);

    // Rejection then two accepts ending the run.
    out_ready = 1'b1;
    vals = '{8'h0D, 8'h0B, 8'h02};
    base = n_out;
    go(5, 2);
    wait_idle("t40_idle", 20);
    tick(3);
    chk("t40_reject_cnt", 32'(reject_cnt), 32'd1);
    chk("t40_outputs", 32'(n_out - base), 32'd2);

    // limit 1 fills the FIFO with zeros and stalls the LFSR.
    out_ready = 1'b0;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    go(1, 0);
    tick(10);
    chk("t41_enable_full", 32'(lfsr_enable), 32'd0);
    chk("t41_head_kept", 32'(lfsr_value), 32'h55);
    chk("t41_busy", 32'(busy), 32'd1);

    // Drain a full FIFO while pushing concurrently.
    vals.delete();
    rnd = 1'b1;
    out_ready = 1'b1;
    tick(12);
    go(0, 0);
    tick(8);
    chk("t44_err", 32'(err), 32'd1);

    // limit 0 from idle.
    go(0, 5);
    tick(4);
    chk("t42_err", 32'(err), 32'd1);
    chk("t42_enable", 32'(lfsr_enable), 32'd0);

    // Lockup on a repeated word.
    rnd = 1'b0;
    out_ready = 1'b0;
    vals = '{8'h10, 8'h37, 8'h37};
    base = n_out;
    go(200, 0);
    wait_idle("t43_idle", 20);
    chk("t43_stuck", 32'(stuck), 32'd1);
    out_ready = 1'b1;
    tick(6);
    chk("t43_outputs", 32'(n_out - base), 32'd2);

    // Asynchronous reset with three entries buffered.
    vals.delete();
    rnd = 1'b1;
    out_ready = 1'b0;
    go(128, 0);
    tick(3);
    chk("t45_pre_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t45_out_valid", 32'(out_valid), 32'd0);
    chk("t45_out_data", 32'(out_data), 32'd0);
    chk("t45_enable", 32'(lfsr_enable), 32'd0);
    chk("t45_busy", 32'(busy), 32'd0);
    chk("t45_flags", 32'({stuck, err}), 32'd0);
    chk("t45_reject", 32'(reject_cnt), 32'd0);
    #1 reset = 1'b1;
    tick(2);

    // Randomized runs.
    for (int it = 0; it < 40; it++) begin
      int l;
      l = ($urandom_range(0, 12) == 0) ? 0 : int'($urandom_range(1, 255));
      go(l, int'($urandom_range(0, 6)));
      repeat ($urandom_range(5, 30)) begin
        out_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    out_ready = 1'b1;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
